// File: rtl/bbox_detect.sv
// rtl/bbox_detect.sv - colour-threshold pixel classifier with run filter and per-frame bounding box.
// Pipeline: stage 1 classifies, stage 2 filters runs and accumulates, stage 3 publishes at frame end.
module bbox_detect #(
  parameter int          H_DISP  = 1024,
  parameter int          V_DISP  = 768,
  parameter logic [4:0]  R_MIN   = 5'd20,
  parameter logic [5:0]  G_MAX   = 6'd24,
  parameter logic [4:0]  B_MAX   = 5'd12,
  parameter int          RUN_LEN = 4,
  parameter logic [19:0] MIN_PIX = 20'd16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic [15:0] data_in,
  output logic [10:0] x_min,
  output logic [10:0] x_max,
  output logic [10:0] y_min,
  output logic [10:0] y_max,
  output logic        obj_valid,
  output logic        frame_done
);

  localparam logic [3:0]  RUN_L   = 4'(RUN_LEN);
  localparam logic [10:0] MIN_INI = 11'h7FF;

  logic        r_armed;
  logic        r_hit_q, r_en_q, r_last_q, r_last_qq;
  logic [10:0] r_x_q, r_y_q;
  logic [3:0]  r_run;
  logic [10:0] r_xmin_acc, r_xmax_acc, r_ymin_acc, r_ymax_acc;
  logic [19:0] r_hit_cnt;
  logic [10:0] r_x_min, r_x_max, r_y_min, r_y_max;
  logic        r_obj_valid, r_frame_done;

  logic        w_origin, w_arm_ok, w_colour, w_last;
  logic [3:0]  w_run_nxt;
  logic        w_first, w_more;
  logic [10:0] w_run_x0;
  logic [10:0] w_xmin_b, w_xmax_b, w_ymin_b, w_ymax_b;
  logic [10:0] w_xmin_n, w_xmax_n, w_ymin_n, w_ymax_n;
  logic [19:0] w_cnt_b, w_cnt_n;
  logic [20:0] w_cnt_sum;
  logic [4:0]  w_cnt_add;

  assign w_origin = en && (x == 11'd0) && (y == 11'd0);
  assign w_arm_ok = r_armed || w_origin;
  assign w_colour = (data_in[15:11] >= R_MIN) && (data_in[10:5] <= G_MAX) && (data_in[4:0] <= B_MAX);
  assign w_last   = en && w_arm_ok && (x == 11'(H_DISP - 1)) && (y == 11'(V_DISP - 1));

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_armed  <= 1'b0;
      r_hit_q  <= 1'b0;
      r_en_q   <= 1'b0;
      r_last_q <= 1'b0;
      r_x_q    <= '0;
      r_y_q    <= '0;
    end else begin
      if (w_origin) r_armed <= 1'b1;
      r_hit_q  <= en && w_colour && w_arm_ok;
      r_en_q   <= en;
      r_last_q <= w_last;
      r_x_q    <= x;
      r_y_q    <= y;
    end
  end

  // On the publish edge the accumulators restart from their initial values, but a pixel
  // already in stage 2 (back-to-back frames) is folded into that fresh state, not lost.
  always_comb begin
    w_run_nxt = r_run;
    if (!r_en_q || !r_hit_q)   w_run_nxt = 4'd0;
    else if (r_x_q == 11'd0)   w_run_nxt = 4'd1;
    else if (r_run != 4'hF)    w_run_nxt = r_run + 4'd1;

    w_first  = r_hit_q && (w_run_nxt == RUN_L);
    w_more   = r_hit_q && (w_run_nxt > RUN_L);
    w_run_x0 = r_x_q - 11'(RUN_LEN - 1);

    w_xmin_b = r_last_qq ? MIN_INI : r_xmin_acc;
    w_xmax_b = r_last_qq ? 11'd0   : r_xmax_acc;
    w_ymin_b = r_last_qq ? MIN_INI : r_ymin_acc;
    w_ymax_b = r_last_qq ? 11'd0   : r_ymax_acc;
    w_cnt_b  = r_last_qq ? 20'd0   : r_hit_cnt;

    w_xmin_n = w_xmin_b;
    w_xmax_n = w_xmax_b;
    w_ymin_n = w_ymin_b;
    w_ymax_n = w_ymax_b;
    if (w_first && (w_run_x0 < w_xmin_b)) w_xmin_n = w_run_x0;
    if (w_first || w_more) begin
      if (r_x_q > w_xmax_b) w_xmax_n = r_x_q;
      if (r_y_q < w_ymin_b) w_ymin_n = r_y_q;
      if (r_y_q > w_ymax_b) w_ymax_n = r_y_q;
    end

    w_cnt_add = w_first ? 5'(RUN_LEN) : (w_more ? 5'd1 : 5'd0);
    w_cnt_sum = {1'b0, w_cnt_b} + 21'(w_cnt_add);
    w_cnt_n   = w_cnt_sum[20] ? 20'hFFFFF : w_cnt_sum[19:0];
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_run        <= 4'd0;
      r_xmin_acc   <= MIN_INI;
      r_xmax_acc   <= '0;
      r_ymin_acc   <= MIN_INI;
      r_ymax_acc   <= '0;
      r_hit_cnt    <= '0;
      r_last_qq    <= 1'b0;
      r_frame_done <= 1'b0;
      r_x_min      <= '0;
      r_x_max      <= '0;
      r_y_min      <= '0;
      r_y_max      <= '0;
      r_obj_valid  <= 1'b0;
    end else begin
      r_run        <= w_run_nxt;
      r_xmin_acc   <= w_xmin_n;
      r_xmax_acc   <= w_xmax_n;
      r_ymin_acc   <= w_ymin_n;
      r_ymax_acc   <= w_ymax_n;
      r_hit_cnt    <= w_cnt_n;
      r_last_qq    <= r_last_q;
      r_frame_done <= r_last_qq;
      if (r_last_qq) begin
        if (r_hit_cnt >= MIN_PIX) begin
          r_x_min     <= r_xmin_acc;
          r_x_max     <= r_xmax_acc;
          r_y_min     <= r_ymin_acc;
          r_y_max     <= r_ymax_acc;
          r_obj_valid <= 1'b1;
        end else begin
          r_x_min     <= '0;
          r_x_max     <= '0;
          r_y_min     <= '0;
          r_y_max     <= '0;
          r_obj_valid <= 1'b0;
        end
      end
    end
  end

  assign x_min      = r_x_min;
  assign x_max      = r_x_max;
  assign y_min      = r_y_min;
  assign y_max      = r_y_max;
  assign obj_valid  = r_obj_valid;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_bbox_detect.sv
// tb/tb_bbox_detect.sv - bench for bbox_detect on a reduced 64x16 raster, two MIN_PIX variants.
module tb_bbox_detect;
  localparam int H  = 64;
  localparam int V  = 16;
  localparam int RL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [10:0] x = '0, y = '0;
  logic [15:0] data_in = '0;
  logic [10:0] a_x_min, a_x_max, a_y_min, a_y_max;
  logic [10:0] b_x_min, b_x_max, b_y_min, b_y_max;
  logic        a_ov, a_fd, b_ov, b_fd;

  bbox_detect #(.H_DISP(H), .V_DISP(V), .R_MIN(5'd20), .G_MAX(6'd24), .B_MAX(5'd12),
                .RUN_LEN(RL), .MIN_PIX(20'd16)) dut16 (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .y(y), .data_in(data_in),
    .x_min(a_x_min), .x_max(a_x_max), .y_min(a_y_min), .y_max(a_y_max),
    .obj_valid(a_ov), .frame_done(a_fd));

  bbox_detect #(.H_DISP(H), .V_DISP(V), .R_MIN(5'd20), .G_MAX(6'd24), .B_MAX(5'd12),
                .RUN_LEN(RL), .MIN_PIX(20'd4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .y(y), .data_in(data_in),
    .x_min(b_x_min), .x_max(b_x_max), .y_min(b_y_min), .y_max(b_y_max),
    .obj_valid(b_ov), .frame_done(b_fd));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  logic rst_seen = 1'b1;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst_n;
  end

  // Reference model: samples are split into per-line runs of consecutive hits; runs of at
  // least RL pixels contribute their full extent to the frame box and pixel count.
  typedef struct {int due; int x0; int x1; int y0; int y1; int cnt;} pub_t;
  pub_t pend[$];
  pub_t pub = '{0, 0, 0, 0, 0, 0};
  bit   armed = 0;
  int   run_len = 0, run_start = 0, run_end = 0, run_y = 0;
  int   f_cnt, f_x0, f_x1, f_y0, f_y1;
  int   wx0, wx1, wy0, wy1;
  int   last_e = 0, last_fd_cyc = -1, fd_count = 0;

  task automatic frame_clear();
    f_cnt = 0; f_x0 = 9999; f_x1 = 0; f_y0 = 9999; f_y1 = 0;
  endtask

  task automatic close_run();
    if (run_len >= RL) begin
      f_cnt += run_len;
      if (run_start < f_x0) f_x0 = run_start;
      if (run_end > f_x1)   f_x1 = run_end;
      if (run_y < f_y0)     f_y0 = run_y;
      if (run_y > f_y1)     f_y1 = run_y;
    end
    run_len = 0;
  endtask

  task automatic model_reset();
    armed = 0; run_len = 0; frame_clear();
  endtask

  task automatic model_sample(input bit e_, input int xx, input int yy, input logic [15:0] d, input int ec);
    bit hit;
    if (!e_) begin close_run(); return; end
    if (!armed && !(xx == 0 && yy == 0)) begin close_run(); return; end
    armed = 1;
    hit = (d[15:11] >= 5'd20) && (d[10:5] <= 6'd24) && (d[4:0] <= 5'd12);
    if (!hit || xx == 0) close_run();
    if (hit) begin
      if (run_len == 0) begin run_start = xx; run_y = yy; end
      run_len++;
      run_end = xx;
    end
    if (xx == H - 1 && yy == V - 1) begin
      close_run();
      pend.push_back('{ec + 3, f_x0, f_x1, f_y0, f_y1, f_cnt});
      frame_clear();
    end
  endtask

  task automatic cmp_dut(input string nm, input int minpix, input bit efd, input logic fd,
                         input logic [10:0] ax0, input logic [10:0] ax1, input logic [10:0] ay0,
                         input logic [10:0] ay1, input logic ov);
    bit v;
    int e0, e1, e2, e3;
    v  = pub.cnt >= minpix;
    e0 = v ? pub.x0 : 0; e1 = v ? pub.x1 : 0; e2 = v ? pub.y0 : 0; e3 = v ? pub.y1 : 0;
    n_checks++;
    if (fd !== efd || ov !== v || ax0 !== 11'(e0) || ax1 !== 11'(e1) || ay0 !== 11'(e2) || ay1 !== 11'(e3)) begin
      n_err++;
      $display("FAIL %s cyc=%0d got fd=%0b box=(%0d,%0d,%0d,%0d) valid=%0b expected fd=%0b box=(%0d,%0d,%0d,%0d) valid=%0b",
               nm, cyc, fd, ax0, ax1, ay0, ay1, ov, efd, e0, e1, e2, e3, v);
    end
  endtask

  always @(negedge clk) begin
    bit efd;
    efd = 0;
    if (rst_seen) begin
      pend.delete();
      pub = '{0, 0, 0, 0, 0, 0};
    end else if (pend.size() > 0 && pend[0].due == cyc) begin
      pub = pend.pop_front();
      efd = 1;
    end
    cmp_dut("dut16", 16, efd, a_fd, a_x_min, a_x_max, a_y_min, a_y_max, a_ov);
    cmp_dut("dut4",  4,  efd, b_fd, b_x_min, b_x_max, b_y_min, b_y_max, b_ov);
    if (a_fd === 1'b1) begin last_fd_cyc = cyc; fd_count++; end
  end

  task automatic lit(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic lit_box(input string nm, input int e0, input int e1, input int e2, input int e3,
                         input int ev, input bit use_b);
    if (use_b) begin
      lit({nm, " x_min"}, int'(b_x_min), e0); lit({nm, " x_max"}, int'(b_x_max), e1);
      lit({nm, " y_min"}, int'(b_y_min), e2); lit({nm, " y_max"}, int'(b_y_max), e3);
      lit({nm, " valid"}, int'(b_ov), ev);
    end else begin
      lit({nm, " x_min"}, int'(a_x_min), e0); lit({nm, " x_max"}, int'(a_x_max), e1);
      lit({nm, " y_min"}, int'(a_y_min), e2); lit({nm, " y_max"}, int'(a_y_max), e3);
      lit({nm, " valid"}, int'(a_ov), ev);
    end
  endtask

  task automatic drive(input bit e_, input int xx, input int yy, input logic [15:0] d);
    @(posedge clk);
    #1;
    en = e_; x = 11'(xx); y = 11'(yy); data_in = d;
    model_sample(e_, xx, yy, d, cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom % H, $urandom % V, 16'($urandom));
  endtask

  task automatic do_reset(input int n);
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst_n = 1'b1; en = 1'b0;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
  endtask

  function automatic logic [15:0] pix(input int kind, input int xx, input int yy);
    logic [15:0] d;
    d = 16'h0000;
    case (kind)
      1: if (xx >= 10 && xx <= 19 && yy >= 5 && yy <= 8) d = 16'hF800;
      2: if (yy >= 1 && yy <= 10 && ((xx >= 20 && xx <= 22) || (xx >= 40 && xx <= 42))) d = 16'hF800;
      3: if ((yy == 10 && xx >= H - 4) || (yy == 11 && xx <= 2)) d = 16'hF800;
      4: d = 16'hF800;
      5: begin
        if (xx >= wx0 && xx <= wx1 && yy >= wy0 && yy <= wy1 && ($urandom % 8) < 6)
          d = {5'($urandom_range(31, 18)), 6'($urandom_range(26, 0)), 5'($urandom_range(14, 0))};
        else
          d = 16'($urandom);
      end
      default: d = 16'h0000;
    endcase
    return d;
  endfunction

  task automatic drive_frame(input int kind, input bit gaps, input int abort_row);
    for (int yy = 0; yy < V; yy++) begin
      for (int xx = 0; xx < H; xx++) begin
        if (yy == abort_row && xx == 0) do_reset(2);
        if (gaps && ($urandom % 20) == 0) idle(1 + $urandom % 2);
        drive(1'b1, xx, yy, pix(kind, xx, yy));
      end
    end
    last_e = cyc;
  endtask

  initial begin
    int fdc;
    model_reset();
    do_reset(3);
    idle(20);
    lit("reset fd_count", fd_count, 0);
    lit_box("reset", 0, 0, 0, 0, 0, 0);

    last_fd_cyc = -1;
    drive_frame(1, 0, -1);
    idle(5);
    lit("rect latency", last_fd_cyc - last_e, 3);
    lit_box("rect dut16", 10, 19, 5, 8, 1, 0);
    lit_box("rect dut4", 10, 19, 5, 8, 1, 1);

    drive_frame(2, 0, -1);
    idle(5);
    lit_box("short runs dut16", 0, 0, 0, 0, 0, 0);
    lit_box("short runs dut4", 0, 0, 0, 0, 0, 1);

    drive_frame(3, 0, -1);
    idle(5);
    lit_box("line edge dut16", 0, 0, 0, 0, 0, 0);
    lit_box("line edge dut4", H - 4, H - 1, 10, 10, 1, 1);

    fdc = fd_count;
    drive_frame(1, 0, 10);
    idle(5);
    lit("aborted frame fd_count", fd_count, fdc);
    lit_box("aborted frame", 0, 0, 0, 0, 0, 0);
    drive_frame(1, 0, -1);
    idle(5);
    lit_box("rect after abort", 10, 19, 5, 8, 1, 0);

    drive_frame(4, 0, -1);
    idle(5);
    lit_box("all red", 0, H - 1, 0, V - 1, 1, 0);
    drive_frame(0, 0, -1);
    idle(5);
    lit_box("all black", 0, 0, 0, 0, 0, 0);

    drive_frame(4, 0, -1);
    drive_frame(1, 0, -1);
    for (int f = 0; f < 6; f++) begin
      wx0 = $urandom_range(H - 1, 0); wx1 = $urandom_range(H - 1, wx0);
      wy0 = $urandom_range(V - 1, 0); wy1 = $urandom_range(V - 1, wy0);
      drive_frame(5, 1, -1);
      idle($urandom % 4);
    end
    idle(6);
    lit("pending publishes drained", pend.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #3000000;
    n_err++;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
